shifter_barrel_pipe: RTL and testbench

Pipelined, parametrised successor to the 16-bit combinational barrel shifter. It adds logical-left, logical-right, arithmetic-right and rotate-right modes, with one pipeline stage per shift bit. A valid/ready handshake runs on both sides. It sits between operand fetch and writeback in the lab datapath and sustains one shift per cycle when downstream is ready.

---
 rtl/shifter_barrel_pipe.sv | 101 ++++++++++
 tb/tb_shifter_barrel_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_barrel_pipe.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROR, one register stage per shift-amount bit.
// Latency: SHW cycles from the accepting cycle to out_valid_o; one op per cycle.
// Backpressure: global stall; every stage holds while the output is valid and not taken.
module shifter_barrel_pipe #(
    parameter int  WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       mode_i,
    input  logic [SHW-1:0]   shamt_i,
    input  logic [WIDTH-1:0] src_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                    input logic [1:0]       m,
                                                    input int               s);
        case (m)
            MODE_SLL: return d << s;
            MODE_SRL: return d >> s;
            MODE_SRA: return $unsigned($signed(d) >>> s);
            MODE_ROR: return (d >> s) | (d << (WIDTH - s));
            default:  return d;
        endcase
    endfunction

    logic                          advance;
    logic                          in_fire;

    logic [SHW-1:0]                stg_vld;
    logic [SHW-1:0][WIDTH-1:0]     stg_dat;
    logic [SHW-1:0][1:0]           stg_mode;
    logic [SHW-1:0][SHW-1:0]       stg_shamt;
    logic                          zero_q;

    logic [SHW-1:0]                pre_vld;
    logic [SHW-1:0][WIDTH-1:0]     pre_dat;
    logic [SHW-1:0][1:0]           pre_mode;
    logic [SHW-1:0][SHW-1:0]       pre_shamt;
    logic [SHW-1:0][WIDTH-1:0]     nxt_dat;

    assign advance    = !stg_vld[SHW-1] || out_ready_i;
    assign in_ready_o = advance;
    assign in_fire    = in_valid_i && advance;

    // Stage k sees the previous stage register (or the input port) and applies 2^k.
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign pre_vld[k]   = in_fire;
            assign pre_dat[k]   = src_i;
            assign pre_mode[k]  = mode_i;
            assign pre_shamt[k] = shamt_i;
        end else begin : g_next
            assign pre_vld[k]   = stg_vld[k-1];
            assign pre_dat[k]   = stg_dat[k-1];
            assign pre_mode[k]  = stg_mode[k-1];
            assign pre_shamt[k] = stg_shamt[k-1];
        end
        assign nxt_dat[k] = pre_shamt[k][k] ? shift_step(pre_dat[k], pre_mode[k], 1 << k)
                                            : pre_dat[k];
    end

    // Payload registers only load on a valid op so idle inputs never reach the outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stg_vld   <= '0;
            stg_dat   <= '0;
            stg_mode  <= '0;
            stg_shamt <= '0;
            zero_q    <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < SHW; k++) begin
                stg_vld[k] <= pre_vld[k];
                if (pre_vld[k]) begin
                    stg_dat[k]   <= nxt_dat[k];
                    stg_mode[k]  <= pre_mode[k];
                    stg_shamt[k] <= pre_shamt[k];
                end
            end
            if (pre_vld[SHW-1]) begin
                zero_q <= (nxt_dat[SHW-1] == '0);
            end
        end
    end

    assign out_valid_o = stg_vld[SHW-1];
    assign result_o    = stg_dat[SHW-1];
    assign zero_o      = zero_q;

endmodule

// File: tb/tb_shifter_barrel_pipe.sv
// Bench for shifter_barrel_pipe: vector table plus scoreboard, stall, reset and 32-bit cases.
module tb_shifter_barrel_pipe;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, zero;
    logic [1:0]  mode;
    logic [3:0]  shamt;
    logic [15:0] src, result;

    logic        in_valid32, in_ready32, out_valid32, out_ready32, zero32;
    logic [1:0]  mode32;
    logic [4:0]  shamt32;
    logic [31:0] src32, result32;

    shifter_barrel_pipe #(.WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .mode_i(mode), .shamt_i(shamt), .src_i(src),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result), .zero_o(zero)
    );

    shifter_barrel_pipe #(.WIDTH(32)) dut32 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid32), .in_ready_o(in_ready32),
        .mode_i(mode32), .shamt_i(shamt32), .src_i(src32),
        .out_valid_o(out_valid32), .out_ready_i(out_ready32),
        .result_o(result32), .zero_o(zero32)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  sh;
        logic [15:0] src;
        logic [15:0] res;
        logic        z;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic        z;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    exp_t cur_exp;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   head_seen = 0;
    bit   prev_stall = 0;
    logic [15:0] prev_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [1:0] m, input int sh, input logic [15:0] s);
        logic [31:0] dbl;
        case (m)
            SLL: dbl = {16'h0, s} << sh;
            SRL: dbl = {16'h0, s} >> sh;
            SRA: dbl = {{16{s[15]}}, s} >> sh;
            default: dbl = {s, s} >> sh;
        endcase
        return dbl[15:0];
    endfunction

    // Scoreboard: pop on output transfer, push on input transfer, both seen mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            q.delete();
            head_seen  = 0;
            prev_stall = 0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", {31'b0, out_valid}, 32'd0);
                end else if (!head_seen) begin
                    head_seen = 1;
                    if (q[0].lat) chk("latency", cyc - q[0].acc, 32'd4);
                end
                if (!out_ready) begin
                    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
                    if (prev_stall) chk("stall_hold", {16'b0, result}, {16'b0, prev_res});
                end else if (q.size() > 0) begin
                    chk("result", {16'b0, result}, {16'b0, q[0].res});
                    chk("zero", {31'b0, zero}, {31'b0, q[0].z});
                    void'(q.pop_front());
                    head_seen = 0;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = result;
            if (in_valid && in_ready) begin
                e     = cur_exp;
                e.acc = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [1:0] m, input logic [3:0] sh, input logic [15:0] s,
                        input logic [15:0] r, input logic z, input bit lat);
        int n = 0;
        logic ok;
        mode = m; shamt = sh; src = s;
        cur_exp.res = r; cur_exp.z = z; cur_exp.lat = lat; cur_exp.acc = 0;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            n++;
            @(posedge clk); #1;
        end while (!ok && n < 200);
        if (!ok) chk("send_timeout", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        mode = 2'bxx; shamt = 4'bxxxx; src = 16'hxxxx;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", q.size(), 32'd0);
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("first_valid_timeout", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic send32(input logic [1:0] m, input logic [4:0] sh, input logic [31:0] s,
                          input logic [31:0] r, input string name);
        int n;
        mode32 = m; shamt32 = sh; src32 = s; in_valid32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        n = 1;
        while (!out_valid32 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_latency"}, n, 32'd5);
        chk(name, result32, r);
        @(posedge clk); #1;
    endtask

    vec_t vecs[13];
    logic [1:0]  bm[6];
    logic [3:0]  bs[6];
    logic [15:0] bsrc[6];
    logic [15:0] r;

    initial begin
        vecs[0]  = '{SLL, 4'd4,  16'h00F0, 16'h0F00, 1'b0};
        vecs[1]  = '{SRA, 4'd3,  16'h8000, 16'hF000, 1'b0};
        vecs[2]  = '{SRL, 4'd3,  16'h8000, 16'h1000, 1'b0};
        vecs[3]  = '{SRL, 4'd15, 16'hFFFF, 16'h0001, 1'b0};
        vecs[4]  = '{ROR, 4'd1,  16'h0001, 16'h8000, 1'b0};
        vecs[5]  = '{ROR, 4'd0,  16'h1234, 16'h1234, 1'b0};
        vecs[6]  = '{SLL, 4'd15, 16'h8001, 16'h8000, 1'b0};
        vecs[7]  = '{SLL, 4'd15, 16'h0002, 16'h0000, 1'b1};
        vecs[8]  = '{SRA, 4'd0,  16'h8421, 16'h8421, 1'b0};
        vecs[9]  = '{ROR, 4'd15, 16'h8001, 16'h0003, 1'b0};
        vecs[10] = '{SRA, 4'd15, 16'h7FFF, 16'h0000, 1'b1};
        vecs[11] = '{SRA, 4'd15, 16'h8000, 16'hFFFF, 1'b0};
        vecs[12] = '{ROR, 4'd8,  16'hABCD, 16'hCDAB, 1'b0};

        bm   = '{SLL, SRL, SRA, ROR, SRA, ROR};
        bs   = '{4'd5, 4'd7, 4'd9, 4'd13, 4'd1, 4'd4};
        bsrc = '{16'hA5C3, 16'h8F01, 16'h9234, 16'h00FF, 16'h7FFE, 16'hF00F};

        rst = 1'b0;
        idle();
        out_ready = 1'b1;
        in_valid32 = 1'b0; mode32 = '0; shamt32 = '0; src32 = '0; out_ready32 = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", {16'b0, result}, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd0);
        chk("rst_out_valid32", {31'b0, out_valid32}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            send(vecs[i].mode, vecs[i].sh, vecs[i].src, vecs[i].res, vecs[i].z, 1'b1);
        end
        idle();
        drain();

        // Back-to-back burst with a three-cycle output stall once results start.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    r = model(bm[i], int'(bs[i]), bsrc[i]);
                    send(bm[i], bs[i], bsrc[i], r, (r == 16'h0), 1'b0);
                end
                idle();
            end
            begin
                wait_out_valid();
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset dropped mid-cycle with three ops in flight and the head stalled.
        out_ready = 1'b0;
        send(SLL, 4'd1, 16'h0101, 16'h0202, 1'b0, 1'b0);
        send(SRL, 4'd2, 16'h0F00, 16'h03C0, 1'b0, 1'b0);
        send(ROR, 4'd3, 16'h0007, 16'hE000, 1'b0, 1'b0);
        idle();
        wait_out_valid();
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_result", {16'b0, result}, 32'd0);
        chk("midrst_zero", {31'b0, zero}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("no_stale_valid", {31'b0, out_valid}, 32'd0);
        send(SRL, 4'd2, 16'h00F0, 16'h003C, 1'b0, 1'b1);
        idle();
        drain();

        send32(SRA, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, "w32_sra31");
        send32(ROR, 5'd31, 32'h0000_0001, 32'h0000_0002, "w32_ror31");
        send32(SLL, 5'd16, 32'h0000_ABCD, 32'hABCD_0000, "w32_sll16");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
